// File: rtl/cpu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : cpu_pkg                                                        |
// | Shared opcode encodings, datapath state encoding and the flag struct     |
// | used by the sequential CPU datapath and its iterative multiplier.        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_SBB = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_OR  = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_ROL = 4'd11;
    localparam logic [3:0] OP_ROR = 4'd12;
    localparam logic [3:0] OP_LDI = 4'd13;
    localparam logic [3:0] OP_MOV = 4'd14;
    localparam logic [3:0] OP_MUL = 4'd15;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic c;
        logic z;
    } flags_t;

endpackage
`default_nettype wire

// File: rtl/cpu_seq_mul.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cpu_seq_mul                                                    |
// | Iterative unsigned WIDTH x WIDTH shift-add multiplier, one bit per cycle.|
// | Ports   : clk, rst (sync, active-high), start (latch a/b and begin),     |
// |           a, b (operands), done (1-cycle pulse, product valid),          |
// |           product (2*WIDTH-bit result, held until next start).          |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module cpu_seq_mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_acc_q;
    logic [2*WIDTH-1:0] r_mcand_q;
    logic [WIDTH-1:0]   r_mplier_q;
    logic [CW-1:0]      r_cnt_q;
    logic               r_busy_q;
    logic               r_done_q;

    // Bit 0 is folded in at the start edge, so bits 1..WIDTH-1 take the
    // following WIDTH-1 edges and done is high in the cycle before the
    // WIDTH-th edge after start -- exactly when the datapath writes back.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_q    <= '0;
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_cnt_q    <= '0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_done_q <= 1'b0;
            if (start) begin
                r_acc_q    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                r_mcand_q  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                r_mplier_q <= b >> 1;
                r_cnt_q    <= CW'(1);
                r_busy_q   <= 1'b1;
            end else if (r_busy_q) begin
                if (r_mplier_q[0]) begin
                    r_acc_q <= r_acc_q + r_mcand_q;
                end
                r_mcand_q  <= r_mcand_q << 1;
                r_mplier_q <= r_mplier_q >> 1;
                if (r_cnt_q == CW'(WIDTH-1)) begin
                    r_busy_q <= 1'b0;
                    r_done_q <= 1'b1;
                end else begin
                    r_cnt_q <= r_cnt_q + CW'(1);
                end
            end
        end
    end

    assign done    = r_done_q;
    assign product = r_acc_q;

endmodule
`default_nettype wire

// File: rtl/cpu_seq_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cpu_seq_datapath                                               |
// | Clocked CPU datapath: NREG x WIDTH register file, C/Z flags, 16-opcode   |
// | ALU with valid/ready issue and an iterative multi-cycle MUL.             |
// | Ports   : clk, rst (sync, active-high)                                   |
// |           in_valid/in_ready  instruction issue handshake                 |
// |           op, rd, rs, imm    instruction fields                          |
// |           out_valid, result  completion pulse and value written to rd    |
// |           carry, zero        flag outputs                                |
// |           dbg_addr/dbg_data  combinational register read port            |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module cpu_seq_datapath
    import cpu_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREG  = 4,
    localparam int RIDX  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [RIDX-1:0]  rd,
    input  logic [RIDX-1:0]  rs,
    input  logic [WIDTH-1:0] imm,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    input  logic [RIDX-1:0]  dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] r_regs_q [NREG];
    flags_t           r_flags_q;
    state_t           r_state_q;
    logic             r_out_valid_q;
    logic [WIDTH-1:0] r_result_q;
    logic [RIDX-1:0]  r_mrd_q;
    logic [RIDX-1:0]  r_mrs_q;

    logic [WIDTH-1:0]   w_r;
    logic [WIDTH-1:0]   w_s;
    logic               w_cin;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_alu_res_d;
    logic               w_alu_c_d;
    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_product;

    assign w_r      = r_regs_q[rd];
    assign w_s      = r_regs_q[rs];
    assign w_accept = in_valid && (r_state_q == IDLE);

    // ADC/SBB consume the carry; ADD/SUB share the same adder with cin=0.
    // The extra MSB of each sum is carry-out, or borrow for subtraction.
    assign w_cin = ((op == OP_ADC) || (op == OP_SBB)) && r_flags_q.c;
    assign w_add = {1'b0, w_r} + {1'b0, w_s} + {{WIDTH{1'b0}}, w_cin};
    assign w_sub = {1'b0, w_r} - {1'b0, w_s} - {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        w_alu_res_d = w_r;
        w_alu_c_d   = r_flags_q.c;
        case (op)
            OP_ADD, OP_ADC: {w_alu_c_d, w_alu_res_d} = w_add;
            OP_SUB, OP_SBB: {w_alu_c_d, w_alu_res_d} = w_sub;
            OP_AND:         w_alu_res_d = w_r & w_s;
            OP_OR:          w_alu_res_d = w_r | w_s;
            OP_XOR:         w_alu_res_d = w_r ^ w_s;
            OP_NOT:         w_alu_res_d = ~w_s;
            OP_SHL:         {w_alu_c_d, w_alu_res_d} = {w_r, 1'b0};
            OP_SHR:         {w_alu_res_d, w_alu_c_d} = {1'b0, w_r};
            OP_ROL:         {w_alu_c_d, w_alu_res_d} = {w_r, r_flags_q.c};
            OP_ROR:         {w_alu_res_d, w_alu_c_d} = {r_flags_q.c, w_r};
            OP_LDI:         w_alu_res_d = imm;
            OP_MOV:         w_alu_res_d = w_s;
            default:        ;   // NOP reports r; MUL completes later
        endcase
    end

    assign w_mul_start = w_accept && (op == OP_MUL);

    cpu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (w_r),
        .b       (w_s),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs_q[i] <= '0;
            end
            r_flags_q     <= '0;
            r_state_q     <= IDLE;
            r_out_valid_q <= 1'b0;
            r_result_q    <= '0;
            r_mrd_q       <= '0;
            r_mrs_q       <= '0;
        end else begin
            r_out_valid_q <= 1'b0;
            case (r_state_q)
                IDLE: begin
                    if (w_accept) begin
                        if (op == OP_MUL) begin
                            r_state_q <= MUL;
                            r_mrd_q   <= rd;
                            r_mrs_q   <= rs;
                        end else begin
                            r_out_valid_q <= 1'b1;
                            r_result_q    <= w_alu_res_d;
                            if (op != OP_NOP) begin
                                r_regs_q[rd] <= w_alu_res_d;
                                r_flags_q.c  <= w_alu_c_d;
                                r_flags_q.z  <= (w_alu_res_d == '0);
                            end
                        end
                    end
                end
                MUL: begin
                    // done coincides with the WIDTH-th edge after accept.
                    if (w_mul_done) begin
                        // High half first so that rd==rs keeps the low half.
                        r_regs_q[r_mrs_q] <= w_mul_product[2*WIDTH-1:WIDTH];
                        r_regs_q[r_mrd_q] <= w_mul_product[WIDTH-1:0];
                        r_flags_q.c       <= 1'b0;
                        r_flags_q.z       <= (w_mul_product == '0);
                        r_result_q        <= w_mul_product[WIDTH-1:0];
                        r_out_valid_q     <= 1'b1;
                        r_state_q         <= IDLE;
                    end
                end
                default: r_state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state_q == IDLE);
    assign out_valid = r_out_valid_q;
    assign result    = r_result_q;
    assign carry     = r_flags_q.c;
    assign zero      = r_flags_q.z;
    assign dbg_data  = r_regs_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_cpu_seq_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_cpu_seq_datapath                                            |
// | Self-checking bench for cpu_seq_datapath (WIDTH=8, NREG=4): integer      |
// | reference model, per-cycle compare, and hand-computed literal checks.    |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_cpu_seq_datapath;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic       out_valid;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    cpu_seq_datapath #(
        .WIDTH (8),
        .NREG  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rd        (rd),
        .rs        (rs),
        .imm       (imm),
        .out_valid (out_valid),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------
    int m_regs [4];
    bit m_c, m_z, m_ov;
    int m_res;
    int m_rem;      // edges left until MUL writeback, 0 when idle
    int m_prod;
    int m_mrd, m_mrs;

    always @(posedge clk) begin : model
        int r, s, c, t, res;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_regs[i] <= 0;
            m_c <= 0; m_z <= 0; m_ov <= 0; m_res <= 0; m_rem <= 0;
        end else begin
            m_ov <= 0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_regs[m_mrs] <= m_prod / 256;
                    m_regs[m_mrd] <= m_prod % 256;
                    m_c   <= 0;
                    m_z   <= (m_prod == 0);
                    m_ov  <= 1;
                    m_res <= m_prod % 256;
                end
            end else if (in_valid) begin
                r = m_regs[rd]; s = m_regs[rs]; c = int'(m_c); res = r;
                case (op)
                    4'd1:  begin t = r + s;     res = t % 256; c = t / 256; end
                    4'd2:  begin t = r + s + c; res = t % 256; c = t / 256; end
                    4'd3:  begin res = (r - s + 256) % 256; c = (r < s) ? 1 : 0; end
                    4'd4:  begin res = (r - s - c + 512) % 256; c = (r < s + c) ? 1 : 0; end
                    4'd5:  res = r & s;
                    4'd6:  res = r | s;
                    4'd7:  res = r ^ s;
                    4'd8:  res = 255 - s;
                    4'd9:  begin t = r * 2;       res = t % 256; c = t / 256; end
                    4'd10: begin res = r / 2;     c = r % 2; end
                    4'd11: begin t = r * 2 + c;   res = t % 256; c = t / 256; end
                    4'd12: begin t = c * 256 + r; res = t / 2;   c = t % 2; end
                    4'd13: res = int'(imm);
                    4'd14: res = s;
                    4'd15: begin m_prod <= r * s; m_mrd <= int'(rd); m_mrs <= int'(rs); m_rem <= 8; end
                    default: ;
                endcase
                if (op != 4'd15) begin
                    m_ov  <= 1;
                    m_res <= res;
                    if (op != 4'd0) begin
                        m_regs[rd] <= res;
                        m_c <= (c != 0);
                        m_z <= (res == 0);
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare -----------------------------------
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("in_ready", {31'd0, in_ready}, {31'd0, (m_rem == 0)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
            if (m_ov) chk("result", {24'd0, result}, m_res);
            chk("carry", {31'd0, carry}, {31'd0, m_c});
            chk("zero", {31'd0, zero}, {31'd0, m_z});
            for (int i = 0; i < 4; i++) begin
                dbg_addr = i[1:0];
                #1;
                chk($sformatf("dbg_data r%0d", i), {24'd0, dbg_data}, m_regs[i]);
            end
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic issue(input logic [3:0] o, input logic [1:0] d, input logic [1:0] s,
                         input logic [7:0] im);
        in_valid = 1'b1; op = o; rd = d; rs = s; imm = im;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [7:0] res, input logic c, input logic z);
        chk({name, " valid"},  {31'd0, out_valid}, 32'd1);
        chk({name, " result"}, {24'd0, result}, {24'd0, res});
        chk({name, " carry"},  {31'd0, carry}, {31'd0, c});
        chk({name, " zero"},   {31'd0, zero}, {31'd0, z});
    endtask

    // Waits (bounded) for in_ready after a MUL issue; returns cycles spent low.
    task automatic wait_mul(output int low);
        low = 0;
        while (!in_ready && low < 20) begin
            @(posedge clk); #1;
            low++;
        end
    endtask

    int low;

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 4'd0; rd = 2'd0; rs = 2'd0; imm = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1;
        rst = 1'b0;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", {24'd0, result}, 32'd0);
        chk("reset carry", {31'd0, carry}, 32'd0);
        chk("reset zero", {31'd0, zero}, 32'd0);
        @(posedge clk); #1;

        // add / adc
        issue(4'd13, 2'd0, 2'd0, 8'hCC);
        issue(4'd13, 2'd1, 2'd0, 8'h55);
        issue(4'd1, 2'd0, 2'd1, 8'h00);  expect_out("ADD", 8'h21, 1'b1, 1'b0);
        issue(4'd2, 2'd2, 2'd2, 8'h00);  expect_out("ADC", 8'h01, 1'b0, 1'b0);

        // sub / borrow / rotates / shifts
        issue(4'd13, 2'd0, 2'd0, 8'd10);
        issue(4'd13, 2'd1, 2'd0, 8'd6);
        issue(4'd3, 2'd0, 2'd1, 8'h00);  expect_out("SUB", 8'h04, 1'b0, 1'b0);
        issue(4'd13, 2'd0, 2'd0, 8'd6);
        issue(4'd13, 2'd1, 2'd0, 8'd10);
        issue(4'd3, 2'd0, 2'd1, 8'h00);  expect_out("SUB borrow", 8'hFC, 1'b1, 1'b0);
        issue(4'd13, 2'd2, 2'd0, 8'h80); expect_out("LDI keeps C", 8'h80, 1'b1, 1'b0);
        issue(4'd11, 2'd2, 2'd0, 8'h00); expect_out("ROL", 8'h01, 1'b1, 1'b0);
        issue(4'd12, 2'd2, 2'd0, 8'h00); expect_out("ROR", 8'h80, 1'b1, 1'b0);
        issue(4'd13, 2'd2, 2'd0, 8'h01);
        issue(4'd10, 2'd2, 2'd0, 8'h00); expect_out("SHR", 8'h00, 1'b1, 1'b1);
        issue(4'd0, 2'd0, 2'd0, 8'h00);  expect_out("NOP", 8'hFC, 1'b1, 1'b1);
        issue(4'd5, 2'd0, 2'd1, 8'h00);  expect_out("AND", 8'h08, 1'b1, 1'b0);
        issue(4'd6, 2'd0, 2'd1, 8'h00);  expect_out("OR", 8'h0A, 1'b1, 1'b0);
        issue(4'd7, 2'd0, 2'd1, 8'h00);  expect_out("XOR", 8'h00, 1'b1, 1'b1);
        issue(4'd8, 2'd3, 2'd1, 8'h00);  expect_out("NOT", 8'hF5, 1'b1, 1'b0);
        issue(4'd9, 2'd3, 2'd0, 8'h00);  expect_out("SHL", 8'hEA, 1'b1, 1'b0);
        issue(4'd4, 2'd3, 2'd1, 8'h00);  expect_out("SBB", 8'hDF, 1'b0, 1'b0);
        issue(4'd14, 2'd2, 2'd3, 8'h00); expect_out("MOV", 8'hDF, 1'b0, 1'b0);
        issue(4'd13, 2'd3, 2'd0, 8'h05);
        issue(4'd3, 2'd3, 2'd3, 8'h00);  expect_out("SUB equal", 8'h00, 1'b0, 1'b1);

        // MUL 10*6 with carry previously set and LDI held during the multiply
        issue(4'd13, 2'd2, 2'd0, 8'h00);
        issue(4'd13, 2'd3, 2'd0, 8'h01);
        issue(4'd3, 2'd2, 2'd3, 8'h00);  expect_out("SUB sets C", 8'hFF, 1'b1, 1'b0);
        issue(4'd13, 2'd0, 2'd0, 8'd10);
        issue(4'd13, 2'd1, 2'd0, 8'd6);
        issue(4'd15, 2'd0, 2'd1, 8'h00);
        in_valid = 1'b1; op = 4'd13; rd = 2'd0; imm = 8'h77;
        wait_mul(low);
        in_valid = 1'b0;
        chk("MUL busy cycles", low, 32'd8);
        expect_out("MUL 10x6", 8'h3C, 1'b0, 1'b0);
        chk("model r0 after MUL", m_regs[0], 32'h3C);
        chk("model r1 after MUL", m_regs[1], 32'h00);

        issue(4'd13, 2'd0, 2'd0, 8'hFF);
        issue(4'd13, 2'd1, 2'd0, 8'hFF);
        issue(4'd15, 2'd0, 2'd1, 8'h00);
        wait_mul(low);
        chk("MUL FFxFF busy", low, 32'd8);
        expect_out("MUL FFxFF", 8'h01, 1'b0, 1'b0);
        chk("model r1 FFxFF hi", m_regs[1], 32'hFE);

        issue(4'd13, 2'd3, 2'd0, 8'h10);
        issue(4'd15, 2'd3, 2'd3, 8'h00);
        wait_mul(low);
        chk("MUL rd==rs busy", low, 32'd8);
        expect_out("MUL r3 r3", 8'h00, 1'b0, 1'b0);

        // reset in the middle of a MUL
        issue(4'd13, 2'd2, 2'd0, 8'h33);
        issue(4'd15, 2'd2, 2'd1, 8'h00);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort carry", {31'd0, carry}, 32'd0);
        chk("model r1 after abort", m_regs[1], 32'd0);
        repeat (12) begin @(posedge clk); #1; end

        // back-to-back LDI every cycle
        for (int i = 0; i < 6; i++) begin
            logic [7:0] v;
            v = 8'(8'h11 * (i + 1));
            issue(4'd13, 2'(i), 2'd0, v);
            chk($sformatf("b2b valid %0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("b2b result %0d", i), {24'd0, result}, {24'd0, v});
        end
        repeat (2) begin @(posedge clk); #1; end

        cmp_en = 0;
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/cpu_seq_datapath.md
Name: cpu_seq_datapath

Overview:
- Parametrised, clocked successor to the combinational CPU datapath.
- Holds an NREG x WIDTH register file plus carry (C) and zero (Z) flags, and executes one 4-bit opcode per accepted instruction.
- Adds a valid/ready issue handshake and an iterative multi-cycle unsigned multiply.
- Sits between the instruction sequencer and the register-visible debug bus of the 8-bit CPU.

Parameters:
- WIDTH, 8, datapath/register width in bits (>=2).
- NREG, 4, number of general registers (power of two, >=2).
- RIDX, $clog2(NREG), register index width (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  datapath can accept an instruction.
- op  in  4  opcode.
- rd  in  RIDX  destination / first-operand register.
- rs  in  RIDX  source / second-operand register.
- imm  in  WIDTH  immediate for LDI.
- out_valid  out  1  one-cycle pulse: an instruction completed.
- result  out  WIDTH  value written to rd by the completed instruction.
- carry  out  1  C flag.
- zero  out  1  Z flag.
- dbg_addr  in  RIDX  debug read index.
- dbg_data  out  WIDTH  combinational read of reg[dbg_addr].

Behaviour:
- Reset: all registers, C, Z, result = 0; out_valid = 0; state IDLE; in_ready = 1 the cycle after reset deasserts.
- An instruction is accepted at a rising edge with in_valid && in_ready; inputs are sampled only then.
- States: IDLE (in_ready=1), MUL (in_ready=0, counter 0..WIDTH-1). Transitions: IDLE->MUL on accepted op 15; MUL->IDLE when counter reaches WIDTH-1.
- Single-cycle ops (0-14): reg/flags updated at the accept edge. out_valid=1 and result valid in the next cycle only. Back-to-back issue every cycle is allowed.
- Opcodes, with r=reg[rd] and s=reg[rs]; all arithmetic modulo 2^WIDTH:
  - 0 NOP: no state change. out_valid still pulses; result = r.
  - 1 ADD: rd=r+s; C=carry out.
  - 2 ADC: rd=r+s+C; C=carry out.
  - 3 SUB: rd=r-s; C=borrow (1 iff r<s unsigned).
  - 4 SBB: rd=r-s-C; C=borrow.
  - 5 AND, 6 OR, 7 XOR: rd=r op s; C unchanged.
  - 8 NOT: rd=~s; C unchanged.
  - 9 SHL: rd=r<<1; C=r[MSB].
  - 10 SHR: rd=r>>1 (logical); C=r[0].
  - 11 ROL: 9-bit-style rotate left through carry: {C,rd} <= {r, C}.
  - 12 ROR: rotate right through carry: {rd,C} <= {C, r}.
  - 13 LDI: rd=imm; C unchanged.
  - 14 MOV: rd=s; C unchanged.
  - 15 MUL: {reg[rs],reg[rd]} = r*s unsigned (2*WIDTH product); C=0.
- Z: set from the value written to rd for ops 1-14 (MUL: Z=1 iff the full product is 0). NOP leaves Z unchanged.
- MUL:
  - Operands are latched at the accept edge.
  - Shift-add, one bit per cycle. Writeback occurs at the WIDTH-th edge after accept; out_valid pulses in the following cycle with result = low half.
  - in_ready=0 from the cycle after accept until writeback.
  - in_valid during MUL is ignored and not queued.
  - Register file is unchanged until writeback; dbg_data shows the old values.
- MUL with rd==rs: only the low half is written to that register; the high half is discarded but still contributes to Z.
- Reset mid-MUL: abort with no writeback. All state returns to reset values.
- Unused opcodes: none; all 16 are defined.

Decomposition:
- Shared package cpu_pkg: opcode localparams OP_NOP..OP_MUL (4-bit), state enum IDLE/MUL, and a flags struct {c,z}.
- One sub-module, cpu_seq_mul: iterative unsigned WIDTH x WIDTH multiplier.
  - Ports: start, a, b -> done, product [2*WIDTH-1:0].
  - Same clk/rst convention.
- Register file and ALU are inline.

Test Plan (WIDTH=8, NREG=4):
- LDI r0=0xCC, r1=0x55, then ADD r0,r1 -> result 0x21, C=1, Z=0. Then ADC r2(=0),r2 -> r2=0x01, C=0.
- LDI r0=10, r1=6; SUB r0,r1 -> r0=0x04, C=0. Then LDI r0=6; SUB r0,r1... with r1=10 -> r0=0xFC, C=1. SUB equal values -> 0x00, Z=1.
- LDI r2=0x80, C=1 (from a prior borrow); ROL r2 -> r2=0x01, C=1. ROR r2 -> r2=0x80, C=1. SHR 0x01 -> 0x00, C=1, Z=1.
- LDI r0=10, r1=6; MUL r0,r1 -> in_ready low exactly 8 cycles; then r0=0x3C, r1=0x00, out_valid one cycle, C=0. in_valid held high with LDI during MUL leaves regs unchanged.
- MUL r0=0xFF, r1=0xFF -> r0=0x01, r1=0xFE. MUL r3,r3 with r3=0x10 -> r3=0x00, Z=0.
- Start MUL, assert rst at cycle 4 -> all regs/flags 0, out_valid never pulses, in_ready=1 after release. Back-to-back LDI on every cycle -> out_valid high continuously and result tracks each imm one cycle later.
